// File: rtl/plot_sequencer.sv
// Program sequencer: fetches instructions from a synchronous memory, runs
// NOP/WAIT/JUMP/HALT locally and hands PLOT words to the datapath via start/finished.
module plot_sequencer #(
  parameter int INSTR_WIDTH  = 32,
  parameter int OPCODE_WIDTH = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int COUNT_WIDTH  = 24
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   run,
  input  logic                   stop,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  input  logic [INSTR_WIDTH-1:0] mem_data,
  output logic [INSTR_WIDTH-1:0] dp_instruction,
  output logic                   dp_start,
  input  logic                   dp_finished,
  output logic                   busy,
  output logic                   halted,
  output logic                   error
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOAD, S_DECODE, S_ISSUE, S_ACK, S_DONE, S_WAIT, S_HALTED
  } state_t;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_PLOT = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_WAIT = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_JUMP = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(4);

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]   ir_q, ir_d;
  logic [COUNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     stop_pend_q, stop_pend_d;
  logic                     dp_start_q, busy_q, halted_q;

  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [COUNT_WIDTH-1:0]   operand;
  logic [ADDR_WIDTH-1:0]    pc_inc;

  assign opcode  = ir_q[INSTR_WIDTH-1 -: OPCODE_WIDTH];
  assign operand = ir_q[COUNT_WIDTH-1:0];
  assign pc_inc  = pc_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (run) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = stop ? S_HALTED : S_LOAD;
      S_LOAD: begin
        if (stop) state_d = S_HALTED;
        else begin
          ir_d    = mem_data;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (stop) state_d = S_HALTED;
        else begin
          case (opcode)
            OP_NOP: begin
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
            OP_PLOT: state_d = S_ISSUE;
            OP_WAIT: begin
              cnt_d = operand;
              if (operand == '0) begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
              end else begin
                state_d = S_WAIT;
              end
            end
            OP_JUMP: begin
              pc_d    = ir_q[ADDR_WIDTH-1:0];
              state_d = S_FETCH;
            end
            OP_HALT: state_d = S_HALTED;
            default: begin
              err_d   = 1'b1;
              pc_d    = pc_inc;
              state_d = S_FETCH;
            end
          endcase
        end
      end
      S_WAIT: begin
        if (stop) begin
          cnt_d   = '0;
          state_d = S_HALTED;
        end else begin
          cnt_d = cnt_q - COUNT_WIDTH'(1);
          if (cnt_q == COUNT_WIDTH'(1)) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
      end
      // Handshake states: stop is deferred until the datapath has finished.
      S_ISSUE: begin
        if (stop) stop_pend_d = 1'b1;
        if (dp_finished) state_d = S_ACK;
      end
      S_ACK: begin
        if (stop) stop_pend_d = 1'b1;
        if (!dp_finished) state_d = S_DONE;
      end
      S_DONE: begin
        if (stop) stop_pend_d = 1'b1;
        if (dp_finished) begin
          pc_d    = pc_inc;
          state_d = (stop_pend_q || stop) ? S_HALTED : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_HALTED) stop_pend_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      dp_start_q  <= 1'b0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      stop_pend_q <= stop_pend_d;
      dp_start_q  <= (state_d == S_ISSUE);
      busy_q      <= !(state_d inside {S_IDLE, S_HALTED});
      halted_q    <= (state_d == S_HALTED);
    end
  end

  assign mem_addr       = pc_q;
  assign dp_instruction = ir_q;
  assign dp_start       = dp_start_q;
  assign busy           = busy_q;
  assign halted         = halted_q;
  assign error          = err_q;

endmodule

// File: tb/tb_plot_sequencer.sv
// Bench for plot_sequencer: program memory and datapath models, vector table,
// corner-case sequences and random programs against an instruction-level model.
module tb_plot_sequencer;

  logic        clock = 1'b0;
  logic        resetn, run, stop;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data;
  logic [31:0] dp_instruction;
  logic        dp_start, busy, halted, error;
  logic        dp_fin = 1'b1;
  int          dp_cnt = 0;
  int          plot_lat = 2;

  logic [31:0] mem [256];
  logic [31:0] got_q[$], exp_q[$], tr_instr[$];
  bit          tr_start[$];
  int          first_addr;
  logic        first_err;
  int          n_chk = 0, n_fail = 0;

  localparam logic [31:0] HALTW = 32'h4000_0000;

  plot_sequencer dut (
    .clock(clock), .resetn(resetn), .run(run), .stop(stop),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .dp_instruction(dp_instruction), .dp_start(dp_start), .dp_finished(dp_fin),
    .busy(busy), .halted(halted), .error(error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) mem_data <= mem[mem_addr];

  // Datapath: accepts start while idle, then reports not-finished for plot_lat cycles.
  always @(posedge clock) begin
    if (dp_cnt > 0) begin
      dp_cnt <= dp_cnt - 1;
      if (dp_cnt == 1) dp_fin <= 1'b1;
    end else if (dp_start && dp_fin) begin
      dp_fin <= 1'b0;
      dp_cnt <= plot_lat;
    end
  end

  function automatic logic [31:0] mk(input int op, input int arg);
    return {op[3:0], arg[27:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) mem[i] = HALTW;
  endtask

  task automatic run_prog(output int cyc, output int starts);
    bit prev;
    prev = 1'b0;
    cyc = 0;
    starts = 0;
    got_q.delete(); tr_instr.delete(); tr_start.delete();
    @(negedge clock); run = 1'b1;
    @(negedge clock); run = 1'b0;
    first_addr = int'(mem_addr);
    first_err  = error;
    for (int i = 0; i < 5000 && !halted; i++) begin
      if (busy) cyc++;
      tr_instr.push_back(dp_instruction);
      tr_start.push_back(dp_start);
      if (dp_start) begin
        starts++;
        if (!prev) got_q.push_back(dp_instruction);
      end
      prev = dp_start;
      @(negedge clock);
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_start(input string nm);
    int k;
    k = 0;
    while (!dp_start && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk(nm, {31'd0, dp_start}, 32'd1);
  endtask

  // Instruction-level reference: each instruction costs 3 cycles of fetch/decode,
  // WAIT n adds n, PLOT adds issue + ack + plot_lat.
  task automatic model(input int lat, output int cyc, output logic [7:0] pc, output logic err);
    logic [31:0] w;
    bit done;
    pc = 8'd0; cyc = 0; err = 1'b0; done = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 1000 && !done; k++) begin
      w = mem[pc];
      cyc += 3;
      case (w[31:28])
        4'd0: pc = pc + 8'd1;
        4'd1: begin cyc += 2 + lat; exp_q.push_back(w); pc = pc + 8'd1; end
        4'd2: begin cyc += int'(w[23:0]); pc = pc + 8'd1; end
        4'd3: pc = w[7:0];
        4'd4: done = 1'b1;
        default: begin err = 1'b1; pc = pc + 8'd1; end
      endcase
    end
  endtask

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          lat;
    int          cyc;
    logic [7:0]  pc;
    logic        err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int cyc, starts, s, ecyc;
    logic [7:0] epc;
    logic eerr;
    logic [31:0] pw;

    tbl[0] = '{mk(0, 0),         HALTW, 1, 6,  8'd1, 1'b0};
    tbl[1] = '{mk(2, 5),         HALTW, 1, 11, 8'd1, 1'b0};
    tbl[2] = '{mk(2, 0),         HALTW, 1, 6,  8'd1, 1'b0};
    tbl[3] = '{32'hF000_0000,    HALTW, 1, 6,  8'd1, 1'b1};
    tbl[4] = '{HALTW,            HALTW, 1, 3,  8'd0, 1'b0};
    tbl[5] = '{mk(3, 5),         HALTW, 1, 6,  8'd5, 1'b0};
    tbl[6] = '{mk(1, 'h123),     HALTW, 3, 11, 8'd1, 1'b0};
    tbl[7] = '{mk(5, 0),         HALTW, 1, 6,  8'd1, 1'b1};
    tbl[8] = '{mk(2, 1),         HALTW, 1, 7,  8'd1, 1'b0};

    resetn = 1'b0; run = 1'b0; stop = 1'b0;
    fill_halt();
    repeat (2) @(negedge clock);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_dp_instr", dp_instruction, 32'd0);
    chk("rst_flags", {28'd0, dp_start, busy, halted, error}, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_no_run", {30'd0, busy, halted}, 32'd0);

    foreach (tbl[i]) begin
      fill_halt();
      mem[0] = tbl[i].w0;
      mem[1] = tbl[i].w1;
      plot_lat = tbl[i].lat;
      run_prog(cyc, starts);
      chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("tbl%0d_pc", i), {24'd0, mem_addr}, {24'd0, tbl[i].pc});
      chk($sformatf("tbl%0d_error", i), {31'd0, error}, {31'd0, tbl[i].err});
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, 32'd0);
      chk($sformatf("tbl%0d_first_addr", i), first_addr, 0);
      chk($sformatf("tbl%0d_first_err", i), {31'd0, first_err}, 32'd0);
    end

    // Single PLOT with a 2-cycle datapath.
    pw = 32'h1000_0000 | (1 << 18) | (5 << 15) | (20 << 8) | 10;
    fill_halt();
    mem[0] = pw;
    plot_lat = 2;
    run_prog(cyc, starts);
    chk("plot_cycles", cyc, 10);
    chk("plot_start_cycles", starts, 1);
    chk("plot_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("plot_word", got_q[0], 32'h1006_940A);
    s = -1;
    foreach (tr_start[j]) if (tr_start[j] && s < 0) s = j;
    if (s >= 0 && s + 3 < tr_instr.size())
      for (int j = 0; j < 4; j++) chk($sformatf("plot_hold%0d", j), tr_instr[s + j], pw);
    chk("plot_pc", {24'd0, mem_addr}, 32'd1);
    chk("plot_halted", {30'd0, halted, busy}, 32'd2);

    // NOP; JUMP 0 loops between addresses 0 and 1.
    fill_halt();
    mem[0] = mk(0, 0);
    mem[1] = mk(3, 0);
    @(negedge clock); run = 1'b1;
    @(negedge clock); run = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("loop_addr%0d", i), {24'd0, mem_addr}, (i / 3) % 2);
      @(negedge clock);
    end
    stop = 1'b1;
    @(negedge clock); stop = 1'b0;
    chk("loop_stop_halted", {31'd0, halted}, 32'd1);

    // Address wrap from 0xFF to 0x00.
    fill_halt();
    mem[0]   = mk(3, 'hFF);
    mem[255] = mk(0, 0);
    @(negedge clock); run = 1'b1;
    @(negedge clock); run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) chk("wrap_ff", {24'd0, mem_addr}, 32'hFF);
      if (i == 6) chk("wrap_00", {24'd0, mem_addr}, 32'h00);
      @(negedge clock);
    end
    stop = 1'b1;
    @(negedge clock); stop = 1'b0;
    chk("wrap_stop_halted", {31'd0, halted}, 32'd1);

    // stop during ACK of a PLOT at pc=3.
    fill_halt();
    mem[0] = mk(0, 0); mem[1] = mk(0, 0); mem[2] = mk(0, 0);
    mem[3] = mk(1, 'h55); mem[4] = mk(0, 0);
    plot_lat = 4;
    @(negedge clock); run = 1'b1;
    @(negedge clock); run = 1'b0;
    wait_start("ack_start_seen");
    @(negedge clock);
    chk("ack_start_low", {31'd0, dp_start}, 32'd0);
    stop = 1'b1;
    @(negedge clock); stop = 1'b0;
    for (int k = 0; k < 50 && !halted; k++) @(negedge clock);
    chk("ack_halted", {31'd0, halted}, 32'd1);
    chk("ack_pc", {24'd0, mem_addr}, 32'd4);
    chk("ack_dp_done", {31'd0, dp_fin}, 32'd1);

    // stop during WAIT 100.
    fill_halt();
    mem[0] = mk(2, 100);
    @(negedge clock); run = 1'b1;
    @(negedge clock); run = 1'b0;
    repeat (10) @(negedge clock);
    stop = 1'b1;
    @(negedge clock); stop = 1'b0;
    chk("wait_stop_halted", {30'd0, halted, busy}, 32'd2);
    chk("wait_stop_pc", {24'd0, mem_addr}, 32'd0);

    // Reset while in DONE of a PLOT at pc=2.
    fill_halt();
    mem[0] = mk(0, 0); mem[1] = mk(0, 0); mem[2] = mk(1, 'h777);
    plot_lat = 6;
    @(negedge clock); run = 1'b1;
    @(negedge clock); run = 1'b0;
    wait_start("done_start_seen");
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    chk("done_rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("done_rst_instr", dp_instruction, 32'd0);
    chk("done_rst_flags", {28'd0, dp_start, busy, halted, error}, 32'd0);
    resetn = 1'b1;
    repeat (10) @(negedge clock);

    // Random programs in addresses 0..15; jumps only go forward so every program halts.
    for (int t = 0; t < 40; t++) begin
      fill_halt();
      for (int a = 0; a < 15; a++) begin
        int r;
        r = $urandom_range(0, 9);
        case (r)
          0, 1: mem[a] = mk(0, $urandom);
          2, 3: mem[a] = mk(1, $urandom);
          4, 5: mem[a] = mk(2, $urandom_range(0, 6));
          6:    mem[a] = mk(3, $urandom_range(a + 1, 15));
          7:    mem[a] = mk(4, 0);
          default: mem[a] = mk($urandom_range(5, 15), $urandom);
        endcase
      end
      plot_lat = $urandom_range(1, 4);
      model(plot_lat, ecyc, epc, eerr);
      run_prog(cyc, starts);
      chk($sformatf("rnd%0d_cycles", t), cyc, ecyc);
      chk($sformatf("rnd%0d_pc", t), {24'd0, mem_addr}, {24'd0, epc});
      chk($sformatf("rnd%0d_error", t), {31'd0, error}, {31'd0, eerr});
      chk($sformatf("rnd%0d_nplots", t), got_q.size(), exp_q.size());
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++)
        chk($sformatf("rnd%0d_plot%0d", t, j), got_q[j], exp_q[j]);
      repeat (2) @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
